// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding issue controller between a command/response handshake pair and a
// pipelined FPU: latches operands, pulses the request, waits with timeout, holds the response.
module fpu_issue_ctrl #(
  parameter  int EXPONENT_WIDTH = 8,
  parameter  int MANTISSA_WIDTH = 23,
  parameter  int TIMEOUT_CYCLES = 3,
  localparam int W              = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  // upstream command
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [2:0]   cmd_op,
  // FPU request
  output logic         fpu_valid_in,
  output logic [W-1:0] fpu_operand_a,
  output logic [W-1:0] fpu_operand_b,
  output logic [2:0]   fpu_operation,
  // FPU response
  input  logic [W-1:0] fpu_result,
  input  logic         fpu_valid_out,
  input  logic         fpu_exception,
  // downstream response
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_exception,
  output logic         rsp_timeout,
  // status
  output logic         busy,
  output logic         protocol_err,
  output logic [7:0]   timeout_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_e       state_q;
  logic [7:0]   wait_cnt_q;
  logic         fpu_valid_in_q;
  logic [W-1:0] op_a_q;
  logic [W-1:0] op_b_q;
  logic [2:0]   op_q;
  logic         rsp_valid_q;
  logic [W-1:0] rsp_result_q;
  logic         rsp_exception_q;
  logic         rsp_timeout_q;
  logic         protocol_err_q;
  logic [7:0]   timeout_cnt_q;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      wait_cnt_q      <= 8'd0;
      fpu_valid_in_q  <= 1'b0;
      op_a_q          <= '0;
      op_b_q          <= '0;
      op_q            <= 3'd0;
      rsp_valid_q     <= 1'b0;
      rsp_result_q    <= '0;
      rsp_exception_q <= 1'b0;
      rsp_timeout_q   <= 1'b0;
      protocol_err_q  <= 1'b0;
      timeout_cnt_q   <= 8'd0;
    end else begin
      fpu_valid_in_q <= 1'b0;
      // A response outside WAIT has no owner: drop the data, remember the violation.
      if (fpu_valid_out && (state_q != S_WAIT)) begin
        protocol_err_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_a_q         <= cmd_a;
            op_b_q         <= cmd_b;
            op_q           <= cmd_op;
            fpu_valid_in_q <= 1'b1;
            state_q        <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          wait_cnt_q <= 8'd1;
          state_q    <= S_WAIT;
        end

        S_WAIT: begin
          if (fpu_valid_out) begin
            rsp_result_q    <= fpu_result;
            rsp_exception_q <= fpu_exception;
            rsp_timeout_q   <= 1'b0;
            rsp_valid_q     <= 1'b1;
            state_q         <= S_RESP;
          end else if (wait_cnt_q == TIMEOUT_LIM) begin
            rsp_result_q    <= '0;
            rsp_exception_q <= 1'b1;
            rsp_timeout_q   <= 1'b1;
            rsp_valid_q     <= 1'b1;
            state_q         <= S_RESP;
            if (timeout_cnt_q != 8'hFF) begin
              timeout_cnt_q <= timeout_cnt_q + 8'd1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign fpu_valid_in  = fpu_valid_in_q;
  assign fpu_operand_a = op_a_q;
  assign fpu_operand_b = op_b_q;
  assign fpu_operation = op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_exception = rsp_exception_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign protocol_err  = protocol_err_q;
  assign timeout_cnt   = timeout_cnt_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: the FPU side is driven by hand, cycle by cycle,
// and every expected value below is worked out from the intended protocol timing.
module tb_fpu_issue_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [2:0]   cmd_op;
  logic         fpu_valid_in;
  logic [W-1:0] fpu_operand_a;
  logic [W-1:0] fpu_operand_b;
  logic [2:0]   fpu_operation;
  logic [W-1:0] fpu_result;
  logic         fpu_valid_out;
  logic         fpu_exception;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_exception;
  logic         rsp_timeout;
  logic         busy;
  logic         protocol_err;
  logic [7:0]   timeout_cnt;

  int checks   = 0;
  int failures = 0;

  fpu_issue_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_op        (cmd_op),
    .fpu_valid_in  (fpu_valid_in),
    .fpu_operand_a (fpu_operand_a),
    .fpu_operand_b (fpu_operand_b),
    .fpu_operation (fpu_operation),
    .fpu_result    (fpu_result),
    .fpu_valid_out (fpu_valid_out),
    .fpu_exception (fpu_exception),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_exception (rsp_exception),
    .rsp_timeout   (rsp_timeout),
    .busy          (busy),
    .protocol_err  (protocol_err),
    .timeout_cnt   (timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
  endtask

  initial begin
    rst_n         = 1'b0;
    cmd_valid     = 1'b0;
    cmd_a         = '0;
    cmd_b         = '0;
    cmd_op        = 3'd0;
    fpu_result    = '0;
    fpu_valid_out = 1'b0;
    fpu_exception = 1'b0;
    rsp_ready     = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_busy",      busy,          0);
    check("rst_fvi",       fpu_valid_in,  0);
    check("rst_rsp_valid", rsp_valid,     0);
    check("rst_perr",      protocol_err,  0);
    check("rst_tocnt",     timeout_cnt,   0);
    check("rst_opa",       fpu_operand_a, 0);
    check("rst_result",    rsp_result,    0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", cmd_ready, 1);

    // 1.0 + 1.0, FPU answers two cycles after the request pulse
    send_cmd(32'h3F80_0000, 32'h3F80_0000, 3'b000);
    check("t1_fvi_idle", fpu_valid_in, 0);
    tick();                                     // ISSUE
    cmd_valid = 1'b0;
    check("t1_fvi_issue", fpu_valid_in,  1);
    check("t1_opa",       fpu_operand_a, 32'h3F80_0000);
    check("t1_opb",       fpu_operand_b, 32'h3F80_0000);
    check("t1_op",        fpu_operation, 0);
    check("t1_ready",     cmd_ready,     0);
    check("t1_busy",      busy,          1);
    tick();                                     // WAIT cnt=1
    check("t1_fvi_wait", fpu_valid_in, 0);
    tick();                                     // WAIT cnt=2
    check("t1_no_rsp", rsp_valid, 0);
    fpu_valid_out = 1'b1;
    fpu_result    = 32'h4000_0000;
    fpu_exception = 1'b0;
    tick();                                     // RESP
    fpu_valid_out = 1'b0;
    fpu_result    = 32'hFFFF_FFFF;
    check("t1_rsp_valid", rsp_valid,     1);
    check("t1_result",    rsp_result,    32'h4000_0000);
    check("t1_exc",       rsp_exception, 0);
    check("t1_to",        rsp_timeout,   0);
    check("t1_opa_hold",  fpu_operand_a, 32'h3F80_0000);
    rsp_ready = 1'b1;
    tick();                                     // IDLE
    rsp_ready = 1'b0;
    check("t1_rsp_drop",   rsp_valid,  0);
    check("t1_ready_back", cmd_ready,  1);
    check("t1_result_kept", rsp_result, 32'h4000_0000);

    // 2.0 * 2.0, answer on the last allowed WAIT cycle counts as success
    send_cmd(32'h4000_0000, 32'h4000_0000, 3'b010);
    tick();                                     // ISSUE
    cmd_valid = 1'b0;
    check("t2_op", fpu_operation, 3'b010);
    tick();                                     // WAIT 1
    tick();                                     // WAIT 2
    tick();                                     // WAIT 3
    check("t2_no_rsp", rsp_valid, 0);
    fpu_valid_out = 1'b1;
    fpu_result    = 32'h4080_0000;
    tick();                                     // RESP
    fpu_valid_out = 1'b0;
    check("t2_rsp_valid", rsp_valid,     1);
    check("t2_result",    rsp_result,    32'h4080_0000);
    check("t2_exc",       rsp_exception, 0);
    check("t2_to",        rsp_timeout,   0);
    check("t2_tocnt",     timeout_cnt,   0);
    check("t2_perr",      protocol_err,  0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // FPU never answers: timeout after three WAIT cycles
    send_cmd(32'h0000_0001, 32'h0000_0002, 3'b011);
    tick();                                     // ISSUE
    cmd_valid = 1'b0;
    tick();                                     // WAIT 1
    tick();                                     // WAIT 2
    tick();                                     // WAIT 3
    check("t3_no_rsp", rsp_valid, 0);
    check("t3_busy",   busy,      1);
    tick();                                     // RESP
    check("t3_rsp_valid", rsp_valid,     1);
    check("t3_result",    rsp_result,    0);
    check("t3_exc",       rsp_exception, 1);
    check("t3_to",        rsp_timeout,   1);
    check("t3_tocnt",     timeout_cnt,   1);

    // Backpressure with a pending command: nothing moves until the handshake
    send_cmd(32'h4040_0000, 32'h3F80_0000, 3'b001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", rsp_valid,     1);
      check("t4_hold_to",    rsp_timeout,   1);
      check("t4_hold_ready", cmd_ready,     0);
      check("t4_hold_op",    fpu_operation, 3'b011);
    end
    rsp_ready = 1'b1;
    tick();                                     // IDLE, no bypass accept
    rsp_ready = 1'b0;
    check("t4_idle_ready", cmd_ready,     1);
    check("t4_idle_fvi",   fpu_valid_in,  0);
    check("t4_idle_op",    fpu_operation, 3'b011);
    tick();                                     // ISSUE of second command
    cmd_valid = 1'b0;
    check("t4_fvi",  fpu_valid_in,  1);
    check("t4_opa",  fpu_operand_a, 32'h4040_0000);
    check("t4_op",   fpu_operation, 3'b001);
    tick();                                     // WAIT 1
    fpu_valid_out = 1'b1;
    fpu_result    = 32'h4080_0000;
    fpu_exception = 1'b1;
    tick();                                     // RESP (earliest)
    fpu_valid_out = 1'b0;
    fpu_exception = 1'b0;
    check("t4_rsp_valid", rsp_valid,     1);
    check("t4_result",    rsp_result,    32'h4080_0000);
    check("t4_exc",       rsp_exception, 1);
    check("t4_to",        rsp_timeout,   0);
    check("t4_tocnt",     timeout_cnt,   1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Stray FPU response while idle
    fpu_valid_out = 1'b1;
    fpu_result    = 32'hDEAD_BEEF;
    tick();
    fpu_valid_out = 1'b0;
    check("t5_perr",   protocol_err, 1);
    check("t5_no_rsp", rsp_valid,    0);
    check("t5_idle",   busy,         0);
    check("t5_result", rsp_result,   32'h4080_0000);
    tick();
    tick();
    check("t5_perr_sticky", protocol_err, 1);

    // Asynchronous reset in WAIT, then a late FPU answer and a fresh command
    send_cmd(32'h1234_5678, 32'h9ABC_DEF0, 3'b100);
    tick();                                     // ISSUE
    cmd_valid = 1'b0;
    tick();                                     // WAIT 1
    check("t6_busy_wait", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_fvi",   fpu_valid_in,  0);
    check("t6_rst_rsp",   rsp_valid,     0);
    check("t6_rst_busy",  busy,          0);
    check("t6_rst_ready", cmd_ready,     1);
    check("t6_rst_perr",  protocol_err,  0);
    check("t6_rst_tocnt", timeout_cnt,   0);
    check("t6_rst_opa",   fpu_operand_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_ready_after", cmd_ready, 1);
    fpu_valid_out = 1'b1;
    fpu_result    = 32'h0BAD_0BAD;
    tick();
    fpu_valid_out = 1'b0;
    check("t6_late_perr", protocol_err, 1);
    check("t6_late_rsp",  rsp_valid,    0);
    send_cmd(32'h3F80_0000, 32'h4000_0000, 3'b000);
    tick();                                     // ISSUE
    cmd_valid = 1'b0;
    check("t6_fvi", fpu_valid_in, 1);
    tick();                                     // WAIT 1
    tick();                                     // WAIT 2
    fpu_valid_out = 1'b1;
    fpu_result    = 32'h4040_0000;
    tick();                                     // RESP
    fpu_valid_out = 1'b0;
    check("t6_rsp_valid", rsp_valid,   1);
    check("t6_result",    rsp_result,  32'h4040_0000);
    check("t6_to",        rsp_timeout, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t6_done", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter EXPONENT_WIDTH, default 8, FP exponent width.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23, FP mantissa width; W = EXPONENT_WIDTH+MANTISSA_WIDTH+1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 3, max cycles awaiting fpu_valid_out after issue (legal 1..255).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1 / cmd_ready  output  1  upstream command handshake.
REQ-007 cmd_a, cmd_b  input  W  operands; cmd_op  input  3  operation code, passed through unmodified.
REQ-008 fpu_valid_in  output  1 / fpu_operand_a, fpu_operand_b  output  W / fpu_operation  output  3  request to FPU.
REQ-009 fpu_result  input  W / fpu_valid_out  input  1 / fpu_exception  input  1  FPU response.
REQ-010 rsp_valid  output  1 / rsp_ready  input  1  downstream response handshake.
REQ-011 rsp_result  output  W / rsp_exception  output  1 / rsp_timeout  output  1  response payload.
REQ-012 busy  output  1 (state != IDLE); protocol_err  output  1 sticky; timeout_cnt  output  8 saturating.

Function
REQ-013 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; one command outstanding at a time.
REQ-014 cmd_ready SHALL be 1 exactly when state==IDLE (combinational from state only).
REQ-015 IDLE: on cmd_valid&&cmd_ready, latch cmd_a/cmd_b/cmd_op into fpu_operand_a/b/fpu_operation and go ISSUE.
REQ-016 ISSUE: fpu_valid_in=1 for exactly this one cycle; next state WAIT with wait counter=1.
REQ-017 fpu_operand_a/b/fpu_operation SHALL stay stable from ISSUE until the next accepted command.
REQ-018 WAIT: if fpu_valid_out=1, capture fpu_result->rsp_result, fpu_exception->rsp_exception, rsp_timeout=0, go RESP.
REQ-019 WAIT: if fpu_valid_out=0 and counter==TIMEOUT_CYCLES, set rsp_result=0, rsp_exception=1, rsp_timeout=1, increment timeout_cnt (saturate 255), go RESP; else counter+1.
REQ-020 fpu_valid_out on the final WAIT cycle SHALL count as success, not timeout.
REQ-021 Response latency: rsp_valid rises the cycle after capture; earliest 3 cycles after command acceptance.
REQ-022 RESP: rsp_valid=1 with payload held stable until rsp_ready=1; on that edge go IDLE; rsp_valid falls next cycle.
REQ-023 Command acceptance SHALL NOT occur in the same cycle as RESP handshake (no bypass); back-to-back throughput is one command per >=4 cycles.
REQ-024 fpu_valid_out seen in IDLE, ISSUE or RESP SHALL be ignored for data and set protocol_err=1, held until reset.
REQ-025 rsp_result/rsp_exception/rsp_timeout SHALL hold last values after handshake until overwritten.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, fpu_valid_in=0, rsp_valid=0, all data outputs 0, protocol_err=0, timeout_cnt=0, counter=0.
REQ-027 Reset mid-operation SHALL abandon the outstanding command without response; a late fpu_valid_out after release sets protocol_err.
REQ-028 cmd_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-029 cmd 0x3F800000+0x3F800000 op 000, FPU model answers 0x40000000 two cycles after fpu_valid_in -> fpu_valid_in high exactly one cycle, rsp_result=0x40000000, rsp_exception=0, rsp_timeout=0.
REQ-030 cmd 0x40000000*0x40000000 op 010, FPU latency 3 -> rsp_result=0x40800000, rsp_timeout=0 (boundary success).
REQ-031 FPU never answers -> after 3 WAIT cycles rsp_valid=1, rsp_result=0, rsp_exception=1, rsp_timeout=1, timeout_cnt=1.
REQ-032 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp payload stable, cmd_ready=0, second command accepted only after RESP handshake.
REQ-033 fpu_valid_out pulse in IDLE -> protocol_err=1 and stays 1, no rsp_valid, state unchanged.
REQ-034 rst_n asserted during WAIT -> fpu_valid_in, rsp_valid, busy 0 without clock edge; after release, new command completes normally.
